// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end for the pipelined MIPS core.
// Combines a PC sequencer, a credit-limited in-order request port to
// instruction memory and a DEPTH-entry prefetch FIFO feeding decode through a
// valid/ready handshake. Redirects from decode flush the FIFO and discard
// responses still in flight for the old path.
// Optional feature: define FETCH_PERF_EN to add saturating performance counters
// (perf_fetched, perf_dropped, perf_starve).
module fetch_prefetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus_4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped,
  output logic [31:0]           perf_starve
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] pc4_q   [DEPTH];

  logic [CW:0]           credit_used;
  logic                  issue;
  logic                  drop;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         out_after_resp;

  // Entries held plus entries still in flight must never exceed the FIFO size,
  // so every response is guaranteed a slot.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign issue = imem_req && imem_gnt;
  assign drop  = imem_rvalid && (drop_cnt != '0);
  assign push  = imem_rvalid && (drop_cnt == '0) && !redirect;
  assign pop   = id_valid && id_ready && !redirect;

  // A response with nothing outstanding (e.g. stray memory activity) must not
  // wrap the counter.
  assign out_after_resp = (imem_rvalid && (outstanding != '0)) ? outstanding - CW'(1)
                                                               : outstanding;

  assign id_valid     = (count != '0);
  assign id_instr     = instr_q[rptr];
  assign id_pc        = pc_q[rptr];
  assign id_pc_plus_4 = pc4_q[rptr];

  // PC sequencing, credit tracking, stale-response dropping and FIFO update.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
      end
    end else begin
      outstanding <= out_after_resp + CW'(issue);
      if (redirect) begin
        // Everything still in flight belongs to the old path and is discarded.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        rptr     <= wptr;
        drop_cnt <= out_after_resp;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          instr_q[wptr] <= imem_rdata;
          pc_q[wptr]    <= resp_pc;
          pc4_q[wptr]   <= resp_pc + ADDR_WIDTH'(4);
          wptr          <= wptr + PW'(1);
          resp_pc       <= resp_pc + ADDR_WIDTH'(4);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == CW'(DEPTH))));
  assert property (@(posedge clk) disable iff (rst) (outstanding <= CW'(DEPTH)));

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Performance counters; a redirect discards every queued entry and any
  // response arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_starve  <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(pop));
      if (redirect) begin
        perf_dropped <= sat_add(perf_dropped, 32'(count) + 32'(imem_rvalid));
      end else begin
        perf_dropped <= sat_add(perf_dropped, 32'(drop));
      end
      perf_starve <= sat_add(perf_starve, 32'(!id_valid && id_ready));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue with a behavioural in-order
// instruction memory of programmable latency (instruction word = ~address).
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_starve;
`endif

  // 8-bit address instance for wrap-around checks
  logic        req8;
  logic [7:0]  addr8;
  logic        rvalid8;
  logic [31:0] rdata8;
  logic        valid8;
  logic [31:0] instr8;
  logic [7:0]  pc8;
  logic [7:0]  pc4_8;
`ifdef FETCH_PERF_EN
  logic [31:0] pf8_a, pf8_b, pf8_c;
`endif

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;
  req_t mq[$];
  req_t mq8[$];

  fetch_prefetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_starve(perf_starve)
`endif
  );

  fetch_prefetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(8'h00),
    .imem_req(req8), .imem_addr(addr8), .imem_gnt(1'b1),
    .imem_rvalid(rvalid8), .imem_rdata(rdata8),
    .id_valid(valid8), .id_ready(1'b1), .id_instr(instr8),
    .id_pc(pc8), .id_pc_plus_4(pc4_8)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf8_a), .perf_dropped(pf8_b), .perf_starve(pf8_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory for the main instance: captures issues at the edge,
  // returns responses in order 'lat' cycles later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (rst) mq.delete();
      else if (imem_req && imem_gnt) mq.push_back('{cyc + lat, imem_addr});
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // One-cycle memory for the 8-bit instance.
  initial begin
    rvalid8 = 1'b0;
    rdata8  = '0;
    forever begin
      @(posedge clk);
      if (rst) mq8.delete();
      else if (req8) mq8.push_back('{cyc + 1, {24'h0, addr8}});
      #2;
      if (mq8.size() > 0 && mq8[0].due <= cyc) begin
        rvalid8 = 1'b1;
        rdata8  = ~mq8[0].addr;
        void'(mq8.pop_front());
      end else begin
        rvalid8 = 1'b0;
      end
    end
  end

  // Reset both instances, then release; returns 1 time unit into cycle 0.
  task automatic start(input int l, input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b1; id_ready = rdy; lat = l;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1; id_ready = 1'b0; lat = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({imem_req, id_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_ctrl: req/valid=%b required 00", {imem_req, id_valid});
    end
    total++;
    if ({id_instr, id_pc, id_pc_plus_4} !== 96'h0) begin
      bad++; $display("FAIL reset_data: instr=%h pc=%h pc4=%h required all 0", id_instr, id_pc, id_pc_plus_4);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] e;
    start(1, 1'b1);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL seq_first_issue: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      total++;
      if (imem_addr !== 32'(4 * k)) begin
        bad++; $display("FAIL seq_addr[%0d]: got %h required %h", k, imem_addr, 32'(4 * k));
      end
      if (k == 1) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++; $display("FAIL seq_no_bypass: id_valid=%b required 0", id_valid);
        end
      end else begin
        e = 32'(4 * (k - 2));
        total++;
        if ({id_valid, id_pc, id_pc_plus_4, id_instr} !== {1'b1, e, e + 32'd4, ~e}) begin
          bad++; $display("FAIL seq_head[%0d]: v=%b pc=%h pc4=%h instr=%h required pc %h", k, id_valid, id_pc, id_pc_plus_4, id_instr, e);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int issues;
    start(1, 1'b0);
    issues = (imem_req && imem_gnt) ? 1 : 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) issues++;
    end
    total++;
    if (issues !== 4) begin
      bad++; $display("FAIL bp_issue_count: got %0d required 4", issues);
    end
    total++;
    if ({imem_req, id_valid, id_pc} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL bp_full: req=%b valid=%b pc=%h required 0 1 00000000", imem_req, id_valid, id_pc);
    end
    id_ready = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL bp_pop_cycle_req: got %b required 0", imem_req);
    end
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
      bad++; $display("FAIL bp_resume: req=%b addr=%h required 1 00000010", imem_req, imem_addr);
    end
    for (int j = 1; j <= 6; j++) begin
      if (j > 1) @(negedge clk);
      total++;
      if ({id_valid, id_pc} !== {1'b1, 32'(4 * j)}) begin
        bad++; $display("FAIL bp_stream[%0d]: v=%b pc=%h required 1 %h", j, id_valid, id_pc, 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect_drop;
    start(3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rd_req_in_redirect: got %b required 0", imem_req);
    end
    @(negedge clk);
    redirect = 1'b0; imem_gnt = 1'b1;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL rd_reissue: req=%b addr=%h required 1 00000100", imem_req, imem_addr);
    end
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0) begin
        bad++; $display("FAIL rd_stale_c%0d: id_valid=%b pc=%h required valid 0", c, id_valid, id_pc);
      end
    end
    @(negedge clk);
    total++;
    if ({id_valid, id_pc, id_pc_plus_4, id_instr} !== {1'b1, 32'h100, 32'h104, ~32'h100}) begin
      bad++; $display("FAIL rd_first_new: v=%b pc=%h pc4=%h instr=%h required pc 00000100", id_valid, id_pc, id_pc_plus_4, id_instr);
    end
    @(negedge clk);
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h104}) begin
      bad++; $display("FAIL rd_second_new: v=%b pc=%h required 1 00000104", id_valid, id_pc);
    end
  endtask

  task automatic test_redirect_full;
    start(3, 1'b0);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rf_prefill: v=%b pc=%h required 1 00000000", id_valid, id_pc);
    end
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++; $display("FAIL rf_after_redirect: v=%b req=%b addr=%h required 0 1 00000200", id_valid, imem_req, imem_addr);
    end
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if (id_valid !== 1'b0) begin
        bad++; $display("FAIL rf_drop_c%0d: id_valid=%b pc=%h required valid 0", c, id_valid, id_pc);
      end
    end
    @(negedge clk);
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, ~32'h200}) begin
      bad++; $display("FAIL rf_first_new: v=%b pc=%h instr=%h required pc 00000200", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_wrap;
    start(1, 1'b1);
    total++;
    if ({req8, addr8} !== {1'b1, 8'hF8}) begin
      bad++; $display("FAIL wrap_c0: req=%b addr=%h required 1 f8", req8, addr8);
    end
    @(negedge clk);
    total++;
    if (addr8 !== 8'hFC) begin
      bad++; $display("FAIL wrap_c1: addr=%h required fc", addr8);
    end
    @(negedge clk);
    total++;
    if ({addr8, valid8, pc8, pc4_8, instr8} !== {8'h00, 1'b1, 8'hF8, 8'hFC, ~32'hF8}) begin
      bad++; $display("FAIL wrap_c2: addr=%h v=%b pc=%h pc4=%h instr=%h required 00 1 f8 fc", addr8, valid8, pc8, pc4_8, instr8);
    end
    @(negedge clk);
    total++;
    if ({addr8, valid8, pc8, pc4_8} !== {8'h04, 1'b1, 8'hFC, 8'h00}) begin
      bad++; $display("FAIL wrap_c3: addr=%h v=%b pc=%h pc4=%h required 04 1 fc 00", addr8, valid8, pc8, pc4_8);
    end
    @(negedge clk);
    total++;
    if ({valid8, pc8, pc4_8} !== {1'b1, 8'h00, 8'h04}) begin
      bad++; $display("FAIL wrap_c4: v=%b pc=%h pc4=%h required 1 00 04", valid8, pc8, pc4_8);
    end
  endtask

  task automatic test_reset_midway;
    start(3, 1'b0);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rm_prefill: v=%b pc=%h required 1 00000000", id_valid, id_pc);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({id_valid, imem_req} !== 2'b00) begin
      bad++; $display("FAIL rm_cleared: valid/req=%b required 00", {id_valid, imem_req});
    end
`ifdef FETCH_PERF_EN
    total++;
    if ({perf_fetched, perf_dropped, perf_starve} !== 96'h0) begin
      bad++; $display("FAIL rm_perf_zero: %h %h %h required 0", perf_fetched, perf_dropped, perf_starve);
    end
`endif
    rst = 1'b0; id_ready = 1'b1;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rm_refetch: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    for (int c = 1; c <= 3; c++) @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL rm_latency: id_valid=%b required 0", id_valid);
    end
    @(negedge clk);
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rm_first: v=%b pc=%h required 1 00000000", id_valid, id_pc);
    end
    @(negedge clk);
    total++;
    if ({id_valid, id_pc} !== {1'b1, 32'h4}) begin
      bad++; $display("FAIL rm_second: v=%b pc=%h required 1 00000004", id_valid, id_pc);
    end
`ifdef FETCH_PERF_EN
    total++;
    if ({perf_fetched, perf_starve} !== {32'd1, 32'd4}) begin
      bad++; $display("FAIL rm_perf_count: fetched=%0d starve=%0d required 1 4", perf_fetched, perf_starve);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_full();
    test_wrap();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
